// File: rtl/rv_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : rv_frontend
//  Purpose  : RV32I instruction front end for the multi-cycle core. It holds
//             the program counter, fetch latch, registered decoder and the
//             32x32 integer register file with registered, write-first reads.
//  Ports    : i_clk/i_reset_n        clock, synchronous active-low reset
//             i_pc_target/_select/_inc  PC redirect and fetch-advance strobes
//             i_instruction/i_ack    instruction bus return
//             o_addr/o_cyc           fetch address and request
//             o_rs1/o_rs2/o_rd, o_imm_*, o_funct3, o_pc, o_alu_ctrl,
//             o_op1_src/o_op2_src/o_res_src, o_reg_write, o_inst_*
//                                    registered decode outputs
//             i_rd/i_write/i_data    register-file write port
//             o_data1/o_data2        registered read data for o_rs1/o_rs2
//  Revision : 1.0 - initial release
// ============================================================================
module rv_frontend #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc_target,
    input  logic        i_pc_select,
    input  logic        i_pc_inc,
    input  logic [31:0] i_instruction,
    input  logic        i_ack,
    output logic [31:0] o_addr,
    output logic        o_cyc,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_s,
    output logic [31:0] o_imm_b,
    output logic [31:0] o_imm_u,
    output logic [31:0] o_imm_j,
    output logic [31:0] o_imm_c,
    output logic        o_inst_compressed,
    output logic [2:0]  o_funct3,
    output logic [31:0] o_pc,
    output logic [10:0] o_alu_ctrl,
    output logic        o_op1_src,
    output logic [4:0]  o_op2_src,
    output logic [1:0]  o_res_src,
    output logic        o_reg_write,
    output logic        o_inst_jal,
    output logic        o_inst_jalr,
    output logic        o_inst_branch,
    output logic        o_inst_store,
    input  logic [4:0]  i_rd,
    input  logic        i_write,
    input  logic [31:0] i_data,
    output logic [31:0] o_data1,
    output logic [31:0] o_data2
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    // ---------------- PC and fetch latch ----------------
    logic [31:0] r_pc_q, w_pc_d;
    logic        r_cyc_q;
    logic [31:0] r_inst_q;
    logic [31:0] r_inst_pc_q;

    always_comb begin
        w_pc_d = r_pc_q;
        if (i_pc_select) begin
            w_pc_d = i_pc_target;
        end else if (i_pc_inc && i_ack) begin
            w_pc_d = r_pc_q + 32'd4;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pc_q      <= RESET_ADDR;
            r_cyc_q     <= 1'b0;
            r_inst_q    <= '0;
            r_inst_pc_q <= '0;
        end else begin
            r_pc_q  <= w_pc_d;
            r_cyc_q <= 1'b1;
            if (i_ack) begin
                r_inst_q    <= i_instruction;
                r_inst_pc_q <= r_pc_q;
            end
        end
    end

    assign o_addr = r_pc_q;
    assign o_cyc  = r_cyc_q;

    // ---------------- Decode (combinational next-state) ----------------
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1_d;
    logic [10:0] w_alu_d;
    logic        w_op1_d;
    logic [4:0]  w_op2_d;
    logic [1:0]  w_res_d;
    logic        w_rw_d, w_jal_d, w_jalr_d, w_br_d, w_st_d;

    assign w_opc = r_inst_q[6:0];
    assign w_f3  = r_inst_q[14:12];

    always_comb begin
        w_rs1_d  = r_inst_q[19:15];
        w_alu_d  = '0;
        w_op1_d  = 1'b0;
        w_op2_d  = '0;
        w_res_d  = '0;
        w_rw_d   = 1'b0;
        w_jal_d  = 1'b0;
        w_jalr_d = 1'b0;
        w_br_d   = 1'b0;
        w_st_d   = 1'b0;
        case (w_opc)
            c_OPC_OP, c_OPC_OPIMM: begin
                w_rw_d = 1'b1;
                if (w_opc == c_OPC_OPIMM) begin
                    w_op2_d = 5'b00001;
                end
                case (w_f3)
                    // inst[30] is an immediate bit for ADDI, so only OP subtracts
                    3'b000: w_alu_d[0] = (w_opc == c_OPC_OP) && r_inst_q[30];
                    3'b001: w_alu_d[1] = 1'b1;
                    3'b010: begin w_alu_d[4] = 1'b1; w_alu_d[9]  = 1'b1; end
                    3'b011: begin w_alu_d[4] = 1'b1; w_alu_d[10] = 1'b1; end
                    3'b100: begin w_alu_d[5] = 1'b1; w_alu_d[6]  = 1'b1; end
                    3'b101: begin w_alu_d[2] = 1'b1; w_alu_d[3]  = r_inst_q[30]; end
                    3'b110: begin w_alu_d[5] = 1'b1; w_alu_d[7]  = 1'b1; end
                    default: w_alu_d[5] = 1'b1;
                endcase
            end
            c_OPC_LUI: begin
                w_op2_d = 5'b00010;
                w_rs1_d = 5'd0;
                w_rw_d  = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_op1_d = 1'b1;
                w_op2_d = 5'b00010;
                w_rw_d  = 1'b1;
            end
            c_OPC_LOAD: begin
                w_op2_d = 5'b00001;
                w_res_d = 2'b01;
                w_rw_d  = 1'b1;
            end
            c_OPC_STORE: begin
                w_op2_d = 5'b01000;
                w_st_d  = 1'b1;
            end
            c_OPC_BRANCH: begin
                // funct3[0] inverts the condition, funct3[2:1] picks signed/unsigned
                w_br_d      = 1'b1;
                w_alu_d[4]  = 1'b1;
                w_alu_d[8]  = w_f3[0];
                w_alu_d[9]  = (w_f3[2:1] == 2'b10);
                w_alu_d[10] = (w_f3[2:1] == 2'b11);
            end
            c_OPC_JAL: begin
                w_jal_d = 1'b1;
                w_op2_d = 5'b00100;
                w_res_d = 2'b10;
                w_rw_d  = 1'b1;
            end
            c_OPC_JALR: begin
                w_jalr_d = 1'b1;
                w_op2_d  = 5'b00001;
                w_res_d  = 2'b10;
                w_rw_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_rs1 <= '0; o_rs2 <= '0; o_rd <= '0; o_funct3 <= '0;
            o_imm_i <= '0; o_imm_s <= '0; o_imm_b <= '0; o_imm_u <= '0; o_imm_j <= '0;
            o_pc <= '0; o_alu_ctrl <= '0; o_op1_src <= 1'b0; o_op2_src <= '0;
            o_res_src <= '0; o_reg_write <= 1'b0; o_inst_jal <= 1'b0;
            o_inst_jalr <= 1'b0; o_inst_branch <= 1'b0; o_inst_store <= 1'b0;
        end else begin
            o_rs1         <= w_rs1_d;
            o_rs2         <= r_inst_q[24:20];
            o_rd          <= r_inst_q[11:7];
            o_funct3      <= w_f3;
            o_imm_i       <= {{20{r_inst_q[31]}}, r_inst_q[31:20]};
            o_imm_s       <= {{20{r_inst_q[31]}}, r_inst_q[31:25], r_inst_q[11:7]};
            o_imm_b       <= {{19{r_inst_q[31]}}, r_inst_q[31], r_inst_q[7],
                              r_inst_q[30:25], r_inst_q[11:8], 1'b0};
            o_imm_u       <= {r_inst_q[31:12], 12'b0};
            o_imm_j       <= {{11{r_inst_q[31]}}, r_inst_q[31], r_inst_q[19:12],
                              r_inst_q[20], r_inst_q[30:21], 1'b0};
            o_pc          <= r_inst_pc_q;
            o_alu_ctrl    <= w_alu_d;
            o_op1_src     <= w_op1_d;
            o_op2_src     <= w_op2_d;
            o_res_src     <= w_res_d;
            o_reg_write   <= w_rw_d;
            o_inst_jal    <= w_jal_d;
            o_inst_jalr   <= w_jalr_d;
            o_inst_branch <= w_br_d;
            o_inst_store  <= w_st_d;
        end
    end

    assign o_imm_c           = '0;
    assign o_inst_compressed = 1'b0;

    // ---------------- Register file ----------------
    logic [31:0] r_regs_q [32];
    logic        w_wr_en;
    logic [31:0] w_data1_d, w_data2_d;

    // x0 is never written, so its storage stays zero after reset
    assign w_wr_en   = i_write && (i_rd != 5'd0);
    assign w_data1_d = (w_wr_en && (i_rd == o_rs1)) ? i_data : r_regs_q[o_rs1];
    assign w_data2_d = (w_wr_en && (i_rd == o_rs2)) ? i_data : r_regs_q[o_rs2];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs_q[i] <= '0;
            end
            o_data1 <= '0;
            o_data2 <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs_q[i_rd] <= i_data;
            end
            o_data1 <= w_data1_d;
            o_data2 <= w_data2_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_frontend.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_frontend
//  Purpose  : Scoreboard bench for rv_frontend. Stimulus queues the expected
//             decode for every acknowledged fetch; a monitor pops and compares
//             two edges after the ack and checks read data one edge later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_frontend;

    localparam logic [31:0] RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] i_pc_target = '0;
    logic        i_pc_select = 1'b0, i_pc_inc = 1'b0, i_ack = 1'b0, i_write = 1'b0;
    logic [31:0] i_instruction = '0, i_data = '0;
    logic [4:0]  i_rd = '0;

    logic [31:0] o_addr, o_imm_i, o_imm_s, o_imm_b, o_imm_u, o_imm_j, o_imm_c, o_pc;
    logic [31:0] o_data1, o_data2;
    logic        o_cyc, o_inst_compressed, o_op1_src, o_reg_write;
    logic        o_inst_jal, o_inst_jalr, o_inst_branch, o_inst_store;
    logic [4:0]  o_rs1, o_rs2, o_rd, o_op2_src;
    logic [2:0]  o_funct3;
    logic [10:0] o_alu_ctrl;
    logic [1:0]  o_res_src;

    rv_frontend #(.RESET_ADDR(RST)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_pc_target(i_pc_target),
        .i_pc_select(i_pc_select), .i_pc_inc(i_pc_inc), .i_instruction(i_instruction),
        .i_ack(i_ack), .o_addr(o_addr), .o_cyc(o_cyc), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_rd(o_rd), .o_imm_i(o_imm_i), .o_imm_s(o_imm_s), .o_imm_b(o_imm_b),
        .o_imm_u(o_imm_u), .o_imm_j(o_imm_j), .o_imm_c(o_imm_c),
        .o_inst_compressed(o_inst_compressed), .o_funct3(o_funct3), .o_pc(o_pc),
        .o_alu_ctrl(o_alu_ctrl), .o_op1_src(o_op1_src), .o_op2_src(o_op2_src),
        .o_res_src(o_res_src), .o_reg_write(o_reg_write), .o_inst_jal(o_inst_jal),
        .o_inst_jalr(o_inst_jalr), .o_inst_branch(o_inst_branch),
        .o_inst_store(o_inst_store), .i_rd(i_rd), .i_write(i_write), .i_data(i_data),
        .o_data1(o_data1), .o_data2(o_data2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_c;
        logic        comp;
        logic [31:0] pc;
        logic [10:0] alu;
        logic        op1;
        logic [4:0]  op2;
        logic [1:0]  res;
        logic        rw, jal, jalr, br, st;
    } dec_t;

    dec_t dut_dec;
    assign dut_dec = {o_rs1, o_rs2, o_rd, o_funct3, o_imm_i, o_imm_s, o_imm_b, o_imm_u,
                      o_imm_j, o_imm_c, o_inst_compressed, o_pc, o_alu_ctrl, o_op1_src,
                      o_op2_src, o_res_src, o_reg_write, o_inst_jal, o_inst_jalr,
                      o_inst_branch, o_inst_store};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int CMP = 4, INV = 8, LTS = 9, LTU = 10;
    // ALU control per funct3 for register/immediate arithmetic:
    // ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND
    localparam logic [10:0] ALU_TAB [8] = '{11'h000, 11'h002, 11'h210, 11'h410,
                                            11'h060, 11'h004, 11'h0A0, 11'h020};
    // branch condition per funct3: BEQ, BNE, -, -, BLT, BGE, BLTU, BGEU
    localparam logic [10:0] BR_TAB [8] = '{11'h010, 11'h110, 11'h010, 11'h010,
                                           11'h210, 11'h310, 11'h410, 11'h510};

    function automatic dec_t model_decode(input logic [31:0] inst, input logic [31:0] pc);
        dec_t d;
        logic [31:0] sx;
        int opc, f3;
        d    = '0;
        opc  = int'(inst & 32'h7F);
        f3   = int'((inst >> 12) & 32'h7);
        d.rd  = 5'((inst >> 7) & 32'h1F);
        d.rs1 = 5'((inst >> 15) & 32'h1F);
        d.rs2 = 5'((inst >> 20) & 32'h1F);
        d.f3  = 3'(f3);
        d.pc  = pc;
        sx = $signed(inst) >>> 20;
        d.imm_i = sx;
        sx = $signed(inst) >>> 25;
        d.imm_s = (sx << 5) | ((inst >> 7) & 32'h1F);
        sx = $signed(inst) >>> 31;
        d.imm_b = (sx << 12) | (((inst >> 7) & 32'h1) << 11)
                | (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1);
        d.imm_j = (sx << 20) | (((inst >> 12) & 32'hFF) << 12)
                | (((inst >> 20) & 32'h1) << 11) | (((inst >> 21) & 32'h3FF) << 1);
        d.imm_u = inst & 32'hFFFF_F000;
        case (opc)
            'h33, 'h13: begin
                d.rw  = 1'b1;
                d.alu = ALU_TAB[f3];
                if (opc == 'h13) d.op2 = 5'd1;
                if (inst[30] && (f3 == 5)) d.alu = d.alu | 11'h008;
                if (inst[30] && (f3 == 0) && (opc == 'h33)) d.alu = 11'h001;
            end
            'h37: begin d.op2 = 5'd2; d.rs1 = 5'd0; d.rw = 1'b1; end
            'h17: begin d.op1 = 1'b1; d.op2 = 5'd2; d.rw = 1'b1; end
            'h03: begin d.op2 = 5'd1; d.res = 2'd1; d.rw = 1'b1; end
            'h23: begin d.op2 = 5'd8; d.st = 1'b1; end
            'h63: begin d.br = 1'b1; d.alu = BR_TAB[f3]; end
            'h6F: begin d.jal = 1'b1; d.op2 = 5'd4; d.res = 2'd2; d.rw = 1'b1; end
            'h67: begin d.jalr = 1'b1; d.op2 = 5'd1; d.res = 2'd2; d.rw = 1'b1; end
            default: begin
                d.alu = '0; d.op1 = 1'b0; d.op2 = '0; d.res = '0;
            end
        endcase
        return d;
    endfunction

    function automatic bit is_known_opc(input logic [6:0] o);
        return o inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
    endfunction

    function automatic logic [31:0] rand_inst();
        int k;
        logic [31:0] r;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] o;
        logic [2:0] brf [6];
        brf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        k   = $urandom_range(0, 9);
        r   = $urandom;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        case (k)
            0: return {((f3 == 3'd0 || f3 == 3'd5) && r[31]) ? 7'h20 : 7'h00,
                       rs2, rs1, f3, rd, 7'h33};
            1: begin
                if (f3 == 3'd1) return {7'h00, rs2, rs1, f3, rd, 7'h13};
                if (f3 == 3'd5) return {r[31] ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h13};
                return {r[31:20], rs1, f3, rd, 7'h13};
            end
            2: return {r[31:12], rd, 7'h37};
            3: return {r[31:12], rd, 7'h17};
            4: return {r[31:20], rs1, f3, rd, 7'h03};
            5: return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23};
            6: return {r[31:25], rs2, rs1, brf[$urandom_range(0, 5)], r[11:7], 7'h63};
            7: return {r[31:12], rd, 7'h6F};
            8: return {r[31:20], rs1, 3'd0, rd, 7'h67};
            default: begin
                o = 7'($urandom);
                while (is_known_opc(o)) o = 7'($urandom);
                return {r[31:7], o};
            end
        endcase
    endfunction

    // ---------------- scoreboard state ----------------
    dec_t        dq[$];          // expected decode, one per acknowledged fetch
    logic [9:0]  rq[$];          // {rs1, rs2} awaiting read-data check
    logic [31:0] mregs [32];
    logic [2:0]  pipe = '0;      // ack history: [0]=last edge, [1]=edge before, ...
    logic [31:0] exp_pc = RST;
    logic        exp_cyc = 1'b0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        if (!i_reset_n) begin
            pipe <= '0;
            for (int i = 0; i < 32; i++) mregs[i] <= '0;
        end else begin
            pipe <= {pipe[1:0], i_ack};
            if (i_write && i_rd != 5'd0) mregs[i_rd] <= i_data;
        end
    end

    always @(negedge clk) begin
        dec_t       e;
        logic [9:0] ix;
        if (chk_en) begin
            chk("addr", o_addr, exp_pc);
            chk("cyc", {31'd0, o_cyc}, {31'd0, exp_cyc});
        end
        if (pipe[2]) begin
            if (rq.size() == 0) begin
                chk("data_queue_empty", 32'd1, 32'd0);
            end else begin
                ix = rq.pop_front();
                chk("data1", o_data1, mregs[ix[9:5]]);
                chk("data2", o_data2, mregs[ix[4:0]]);
            end
        end
        if (pipe[1]) begin
            if (dq.size() == 0) begin
                chk("decode_queue_empty", 32'd1, 32'd0);
            end else begin
                e = dq.pop_front();
                tests++;
                if (dut_dec !== e) begin
                    fails++;
                    $display("FAIL decode: got %h, expected %h", dut_dec, e);
                end
                rq.push_back({e.rs1, e.rs2});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic sel, input logic [31:0] tgt, input logic inc,
                         input logic ack, input logic [31:0] inst, input logic wr,
                         input logic [4:0] rd, input logic [31:0] data);
        logic [31:0] nxt;
        i_reset_n = 1'b1;
        i_pc_select = sel; i_pc_target = tgt; i_pc_inc = inc; i_ack = ack;
        i_instruction = inst; i_write = wr; i_rd = rd; i_data = data;
        if (ack) dq.push_back(model_decode(inst, exp_pc));
        if (sel)             nxt = tgt;
        else if (inc && ack) nxt = exp_pc + 32'd4;
        else                 nxt = exp_pc;
        @(posedge clk); #1;
        exp_pc  = nxt;
        exp_cyc = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive($urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, rand_inst(),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    endtask

    // Reset with every other strobe active to show reset overrides them.
    task automatic do_reset();
        chk_en = 1'b0;
        i_reset_n = 1'b0;
        i_pc_select = 1'b1; i_pc_target = 32'h0000_0A00; i_pc_inc = 1'b1; i_ack = 1'b1;
        i_instruction = 32'h0050_0093; i_write = 1'b1; i_rd = 5'd3; i_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", o_addr, RST);
        chk("rst_cyc", {31'd0, o_cyc}, 32'd0);
        chk("rst_data1", o_data1, 32'd0);
        chk("rst_data2", o_data2, 32'd0);
        tests++;
        if (dut_dec !== dec_t'(0)) begin
            fails++;
            $display("FAIL rst_decode: got %h, expected 0", dut_dec);
        end
        exp_pc  = RST;
        exp_cyc = 1'b0;
        chk_en  = 1'b1;
    endtask

    initial begin
        do_reset();
        idle(1);
        chk("cyc_after_reset", {31'd0, o_cyc}, 32'd1);
        chk("addr_after_reset", o_addr, RST);

        // select wins over increment+ack
        drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h0000_0013, 1'b0, '0, '0);
        chk("redirect_priority", o_addr, 32'h200);
        drive(1'b1, 32'h0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
        idle(3);

        // ADDI x1, x0, 5 at PC 0
        drive(1'b0, '0, 1'b1, 1'b1, 32'h0050_0093, 1'b0, '0, '0);
        chk("addi_addr", o_addr, 32'd4);
        idle(1);
        chk("addi_rd", {27'd0, o_rd}, 32'd1);
        chk("addi_rs1", {27'd0, o_rs1}, 32'd0);
        chk("addi_imm", o_imm_i, 32'd5);
        chk("addi_op2", {27'd0, o_op2_src}, 32'd1);
        chk("addi_rw", {31'd0, o_reg_write}, 32'd1);
        chk("addi_pc", o_pc, 32'd0);
        idle(2);

        // BNE x1, x2, +8
        drive(1'b0, '0, 1'b1, 1'b1, 32'h0020_9463, 1'b0, '0, '0);
        idle(1);
        chk("bne_imm_b", o_imm_b, 32'd8);
        chk("bne_alu", {21'd0, o_alu_ctrl}, 32'h110);
        chk("bne_branch", {31'd0, o_inst_branch}, 32'd1);
        chk("bne_rw", {31'd0, o_reg_write}, 32'd0);
        chk("bne_rs", {22'd0, o_rs1, o_rs2}, {22'd0, 5'd1, 5'd2});
        idle(2);

        // LUI x2, 0x12345
        drive(1'b0, '0, 1'b1, 1'b1, 32'h1234_5137, 1'b0, '0, '0);
        idle(1);
        chk("lui_imm_u", o_imm_u, 32'h1234_5000);
        chk("lui_rs1", {27'd0, o_rs1}, 32'd0);
        chk("lui_rd", {27'd0, o_rd}, 32'd2);
        chk("lui_op2", {27'd0, o_op2_src}, 32'd2);
        idle(2);

        // write x5, then read it through an instruction with rs1 = 5
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        drive(1'b0, '0, 1'b1, 1'b1, 32'h0002_8093, 1'b0, '0, '0);
        idle(2);
        chk("x5_read", o_data1, 32'hDEAD_BEEF);

        // x0 ignores writes
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        drive(1'b0, '0, 1'b1, 1'b1, 32'h0000_00B3, 1'b0, '0, '0);
        idle(2);
        chk("x0_read1", o_data1, 32'd0);
        chk("x0_read2", o_data2, 32'd0);

        // write x5 on the same edge that reads it
        drive(1'b0, '0, 1'b1, 1'b1, 32'h0002_8093, 1'b0, '0, '0);
        idle(1);
        drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 5'd5, 32'h0BAD_F00D);
        chk("bypass", o_data1, 32'h0BAD_F00D);
        idle(3);

        rand_cycles(400);
        idle(3);
        do_reset();
        rand_cycles(400);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
